video_pll_seq: RTL and testbench
================================

# video_pll_seq

Reset/lock sequencer for the 720p video pixel-clock PLL (50 MHz reference in, 74.25 MHz out). It drives the PLL's active-high reset and monitors its asynchronous `locked` output. It releases the video pipeline only after lock has been stable for a qualified period. On loss of lock it re-runs the bring-up, and after repeated lock timeouts it parks in a FAIL state. It sits between the board reset and the PLL wrapper and runs entirely on the always-running 50 MHz reference clock.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT for lock (1 ms at 50 MHz).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before RUN.
- `MAX_RETRIES`, 3: consecutive lock timeouts before FAIL (≥1).
- `CNT_W`, derived: `$clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))`.

Ports:
- `refclk` in 1: 50 MHz reference clock; the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `pll_locked` in 1: PLL lock; asynchronous, synchronized internally.
- `restart` in 1: single-cycle software restart request.
- `pll_rst` out 1: active-high reset to the PLL.
- `video_rst_n` out 1: active-low release to the video domain; the receiver re-synchronizes it.
- `ready` out 1: high in RUN.
- `fail` out 1: high in FAIL.
- `state` out 3: HOLD=0, WAIT=1, STABLE=2, RUN=3, FAIL=4.
- `retries` out 2: consecutive timeout count.
- `loss_cnt` out 8: lock-loss events from RUN, saturating at 255.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to give `lock_s`. All decisions use `lock_s`.
- One shared cycle counter `cnt` (CNT_W bits) clears on every state entry.
- HOLD:
  - `pll_rst`=1.
  - When `cnt`==RST_CYCLES-1, go to WAIT.
- WAIT:
  - `pll_rst`=0.
  - If `lock_s`=1, go to STABLE.
  - Otherwise, at `cnt`==LOCK_TIMEOUT-1, increment `retries`. If the new value equals MAX_RETRIES, go to FAIL; otherwise go to HOLD.
- STABLE:
  - If `lock_s`=0, go to WAIT. `cnt` clears, the timeout restarts, and `retries` is unchanged.
  - At `cnt`==STABLE_CYCLES-1 with `lock_s`=1, go to RUN and clear `retries`.
- RUN:
  - `video_rst_n`=1, `ready`=1.
  - If `lock_s`=0, go to HOLD and increment `loss_cnt` (saturating).
- FAIL:
  - `pll_rst`=1, `fail`=1.
  - Exit only via `restart` or `rst_n`.
- `restart`=1 in any state goes to HOLD and clears `retries`. It has priority over every other transition in the same cycle, and `loss_cnt` is not incremented.
- `loss_cnt` is cleared only by `rst_n`.

## Timing
- Reset values:
  - `state`=HOLD, `pll_rst`=1, `video_rst_n`=0.
  - `ready`=0, `fail`=0, `retries`=0, `loss_cnt`=0, `cnt`=0, synchronizer=0.
- All outputs are registered and decoded from the next-state value, so each output changes on the same edge as `state`.
- Synchronizer latency is 2 cycles. `pll_locked` rising is seen by the FSM on the 3rd edge.
- Lock loss to `video_rst_n` low: 3 edges (2 synchronizer + 1 FSM).
- HOLD lasts exactly RST_CYCLES cycles. WAIT timeout is exactly LOCK_TIMEOUT cycles.
- Earliest `ready` after WAIT entry: 1 edge into STABLE after `lock_s`, plus STABLE_CYCLES cycles.
- Lock glitch in STABLE, even for 1 cycle: must return to WAIT; `ready` never asserts.
- `rst_n` asserted mid-operation forces reset values immediately (asynchronously). Deassertion is expected to be synchronized externally.

## Structure
- A shared video package holds:
  - the `pll_seq_state_t` enum (3-bit, encodings above);
  - default parameter constants `PLL_RST_CYCLES`, `PLL_LOCK_TIMEOUT`, `PLL_STABLE_CYCLES`, `PLL_MAX_RETRIES`.
- One sub-module: `sync2`, a generic 2-FF bit synchronizer with async active-low reset, reused for `pll_locked`.
- FSM, counter and status registers live in `video_pll_seq`.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- **Normal bring-up:** release `rst_n`; `pll_locked` rises 5 cycles after `pll_rst` falls.
  - `pll_rst` is high for exactly 4 cycles.
  - `state` goes 0→1→2→3.
  - `ready`/`video_rst_n` rise 8 cycles after STABLE entry.
  - `retries`=0.
- **Timeout then FAIL:** `pll_locked` held 0.
  - Two 20-cycle WAIT windows; `retries` goes 1 then 2.
  - `state`=4, `fail`=1, `pll_rst`=1 and stays so for 100+ cycles.
  - A `restart` pulse then gives `state`=0 and `retries`=0.
- **STABLE glitch:** lock is up, then `pll_locked` drops for 1 cycle after 5 STABLE cycles.
  - Back to WAIT; `ready` stays 0; `retries` unchanged.
  - RUN is reached only after 8 clean cycles.
- **Lock loss in RUN:** drop `pll_locked` while in RUN.
  - `video_rst_n` goes low 3 edges later; `state`=0; `loss_cnt`=1.
  - Re-lock returns to RUN. After 256 losses, `loss_cnt` holds at 255.
- **Simultaneous events:**
  - `restart` on the same edge as the STABLE→RUN transition: HOLD wins and `ready` stays 0.
  - `restart` in RUN: `loss_cnt` is unchanged.
- **Async reset mid-RUN:** assert `rst_n` low between clock edges. All outputs take reset values before the next edge, including `loss_cnt`=0.

Source files
------------

// File: rtl/video_pll_seq_pkg.sv
// Shared video package: PLL sequencer state encoding and default timing constants.
package video_pll_seq_pkg;

   // Default bring-up timing for the 50 MHz reference / 74.25 MHz pixel PLL
   localparam int PLL_RST_CYCLES    = 16;
   localparam int PLL_LOCK_TIMEOUT  = 50000;
   localparam int PLL_STABLE_CYCLES = 1024;
   localparam int PLL_MAX_RETRIES   = 3;

   // Encodings are visible on the state port, so keep them fixed
   typedef enum logic [2:0] {
      PS_HOLD   = 3'd0,
      PS_WAIT   = 3'd1,
      PS_STABLE = 3'd2,
      PS_RUN    = 3'd3,
      PS_FAIL   = 3'd4
   } pll_seq_state_t;

endpackage

// File: rtl/video_pll_seq_sync2.sv
// Generic 2-FF bit synchronizer with async active-low reset.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_pipe;

   // Shift the asynchronous input through two flops; q is the second stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_pipe <= 2'b00;
      else        sync_pipe <= {sync_pipe[0], d};
   end

   assign q = sync_pipe[1];

endmodule

// File: rtl/video_pll_seq.sv
// Reset/lock sequencer for the 720p pixel-clock PLL. Holds the PLL in reset,
// waits for a qualified lock, then releases the video domain. Runs on refclk.
module video_pll_seq
   import video_pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = PLL_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = PLL_STABLE_CYCLES,
   parameter int MAX_RETRIES   = PLL_MAX_RETRIES
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       restart,
   output logic       pll_rst,
   output logic       video_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [2:0] state,
   output logic [1:0] retries,
   output logic [7:0] loss_cnt
);

   localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       RT_MAX   = 2'(MAX_RETRIES);

   logic             lock_s;
   pll_seq_state_t   st, st_nxt;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       rt_nxt;
   logic [7:0]       loss_nxt;

   sync2 u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lock_s)
   );

   // Next-state, retry and loss-count decisions; restart overrides everything
   always_comb begin
      st_nxt   = st;
      rt_nxt   = retries;
      loss_nxt = loss_cnt;
      if (restart) begin
         st_nxt = PS_HOLD;
         rt_nxt = 2'd0;
      end else begin
         case (st)
            PS_HOLD: begin
               if (cnt == RST_LAST) st_nxt = PS_WAIT;
            end
            PS_WAIT: begin
               if (lock_s) begin
                  st_nxt = PS_STABLE;
               end else if (cnt == TO_LAST) begin
                  rt_nxt = retries + 2'd1;
                  st_nxt = (rt_nxt == RT_MAX) ? PS_FAIL : PS_HOLD;
               end
            end
            PS_STABLE: begin
               if (!lock_s) begin
                  st_nxt = PS_WAIT;
               end else if (cnt == STB_LAST) begin
                  st_nxt = PS_RUN;
                  rt_nxt = 2'd0;
               end
            end
            PS_RUN: begin
               if (!lock_s) begin
                  st_nxt = PS_HOLD;
                  if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
               end
            end
            PS_FAIL: st_nxt = PS_FAIL;
            default: st_nxt = PS_HOLD;
         endcase
      end
   end

   // Shared dwell counter: cleared on every state entry (a restart counts as one)
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart || (st_nxt != st)) begin
         cnt <= '0;
      end else if (st == PS_HOLD || st == PS_WAIT || st == PS_STABLE) begin
         cnt <= cnt + 1'b1;
      end
   end

   // State and outputs registered together, decoded from the next state
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= PS_HOLD;
         retries     <= 2'd0;
         loss_cnt    <= 8'd0;
         pll_rst     <= 1'b1;
         video_rst_n <= 1'b0;
         ready       <= 1'b0;
         fail        <= 1'b0;
      end else begin
         st          <= st_nxt;
         retries     <= rt_nxt;
         loss_cnt    <= loss_nxt;
         pll_rst     <= (st_nxt == PS_HOLD) || (st_nxt == PS_FAIL);
         video_rst_n <= (st_nxt == PS_RUN);
         ready       <= (st_nxt == PS_RUN);
         fail        <= (st_nxt == PS_FAIL);
      end
   end

   assign state = st;

endmodule

// File: tb/tb_video_pll_seq.sv
// Bench for video_pll_seq: bring-up vector table with an event scoreboard,
// plus hand sequences for lock loss, restart races, FAIL and async reset.
module tb_video_pll_seq;

   localparam int RC = 4, LT = 20, SC = 8, MR = 2;

   logic       refclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       restart = 1'b0;
   logic       pll_rst, video_rst_n, ready, fail;
   logic [2:0] state;
   logic [1:0] retries;
   logic [7:0] loss_cnt;

   video_pll_seq #(
      .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
      .pll_rst(pll_rst), .video_rst_n(video_rst_n), .ready(ready), .fail(fail),
      .state(state), .retries(retries), .loss_cnt(loss_cnt)
   );

   always #5 refclk = ~refclk;

   // vec: vector id; ed: edge (counted from reset release) of the state change
   typedef struct packed {
      logic [3:0] vec;
      logic [7:0] ed;
      logic [2:0] st;
      logic [1:0] rt;
   } ev_t;

   // lock_after: edge after which pll_locked rises (255 = never)
   // glitch_at: edge after which pll_locked drops for one cycle (0 = none)
   typedef struct packed {
      logic [7:0] lock_after;
      logic [7:0] glitch_at;
      logic [2:0] fin_st;
      logic [1:0] fin_rt;
   } vec_t;

   vec_t vtab[8];
   ev_t  etab[$];
   ev_t  sb[$];
   int   n_chk = 0, n_fail = 0, edge_n = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
      edge_n++;
   endtask

   task automatic ev(input int v, input int ed, input int st, input int rt);
      etab.push_back('{vec: 4'(v), ed: 8'(ed), st: 3'(st), rt: 2'(rt)});
   endtask

   task automatic do_reset();
      @(posedge refclk);
      #1;
      rst_n = 1'b0;
      pll_locked = 1'b0;
      restart = 1'b0;
      #2;
      rst_n = 1'b1;
      edge_n = 0;
   endtask

   task automatic wait_state(input string nm, input int s, input int lim);
      int n;
      n = 0;
      while (state != 3'(s) && n < lim) begin
         tick();
         n++;
      end
      chk(nm, state, s);
   endtask

   task automatic run_vec(input int v);
      logic [2:0] prev;
      ev_t e;
      do_reset();
      foreach (etab[i]) if (etab[i].vec == 4'(v)) sb.push_back(etab[i]);
      if (vtab[v].lock_after == 8'd0) pll_locked = 1'b1;
      prev = state;
      for (int k = 0; k < 70; k++) begin
         tick();
         chk($sformatf("v%0d_outs@%0d", v, edge_n), {pll_rst, video_rst_n, ready, fail},
             {(state == 3'd0 || state == 3'd4), state == 3'd3, state == 3'd3, state == 3'd4});
         if (state != prev) begin
            if (sb.size() == 0) begin
               chk($sformatf("v%0d_unexpected_st@%0d", v, edge_n), state, prev);
            end else begin
               e = sb.pop_front();
               chk($sformatf("v%0d_ev_edge", v), edge_n, e.ed);
               chk($sformatf("v%0d_ev_state@%0d", v, edge_n), state, e.st);
               chk($sformatf("v%0d_ev_retries@%0d", v, edge_n), retries, e.rt);
            end
            prev = state;
         end
         if (edge_n == vtab[v].lock_after) pll_locked = 1'b1;
         if (vtab[v].glitch_at != 8'd0 && edge_n == vtab[v].glitch_at) pll_locked = 1'b0;
         if (vtab[v].glitch_at != 8'd0 && edge_n == vtab[v].glitch_at + 1) pll_locked = 1'b1;
      end
      chk($sformatf("v%0d_sb_left", v), sb.size(), 0);
      chk($sformatf("v%0d_fin_state", v), state, vtab[v].fin_st);
      chk($sformatf("v%0d_fin_retries", v), retries, vtab[v].fin_rt);
      sb.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, held;

      // Vector table: lock timing against the expected state-change edges
      vtab[0] = '{lock_after: 8'd9,   glitch_at: 8'd0,  fin_st: 3'd3, fin_rt: 2'd0};
      vtab[1] = '{lock_after: 8'd4,   glitch_at: 8'd0,  fin_st: 3'd3, fin_rt: 2'd0};
      vtab[2] = '{lock_after: 8'd0,   glitch_at: 8'd0,  fin_st: 3'd3, fin_rt: 2'd0};
      vtab[3] = '{lock_after: 8'd21,  glitch_at: 8'd0,  fin_st: 3'd3, fin_rt: 2'd0};
      vtab[4] = '{lock_after: 8'd22,  glitch_at: 8'd0,  fin_st: 3'd3, fin_rt: 2'd0};
      vtab[5] = '{lock_after: 8'd255, glitch_at: 8'd0,  fin_st: 3'd4, fin_rt: 2'd2};
      vtab[6] = '{lock_after: 8'd9,   glitch_at: 8'd14, fin_st: 3'd3, fin_rt: 2'd0};
      vtab[7] = '{lock_after: 8'd9,   glitch_at: 8'd17, fin_st: 3'd3, fin_rt: 2'd0};
      ev(0, 4, 1, 0); ev(0, 12, 2, 0); ev(0, 20, 3, 0);
      ev(1, 4, 1, 0); ev(1, 7, 2, 0);  ev(1, 15, 3, 0);
      ev(2, 4, 1, 0); ev(2, 5, 2, 0);  ev(2, 13, 3, 0);
      ev(3, 4, 1, 0); ev(3, 24, 2, 0); ev(3, 32, 3, 0);
      ev(4, 4, 1, 0); ev(4, 24, 0, 1); ev(4, 28, 1, 1); ev(4, 29, 2, 1); ev(4, 37, 3, 0);
      ev(5, 4, 1, 0); ev(5, 24, 0, 1); ev(5, 28, 1, 1); ev(5, 48, 4, 2);
      ev(6, 4, 1, 0); ev(6, 12, 2, 0); ev(6, 17, 1, 0); ev(6, 18, 2, 0); ev(6, 26, 3, 0);
      ev(7, 4, 1, 0); ev(7, 12, 2, 0); ev(7, 20, 1, 0); ev(7, 21, 2, 0); ev(7, 29, 3, 0);

      // Reset values while rst_n is held low across edges
      #22;
      chk("rst_state", state, 0);
      chk("rst_pll_rst", pll_rst, 1);
      chk("rst_video_rst_n", video_rst_n, 0);
      chk("rst_ready", ready, 0);
      chk("rst_fail", fail, 0);
      chk("rst_retries", retries, 0);
      chk("rst_loss_cnt", loss_cnt, 0);

      for (int v = 0; v < 8; v++) run_vec(v);

      // restart on the same edge as STABLE->RUN: HOLD wins
      do_reset();
      while (edge_n < 9) tick();
      pll_locked = 1'b1;
      while (edge_n < 19) tick();
      chk("race_pre_state", state, 2);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("race_state", state, 0);
      chk("race_ready", ready, 0);
      chk("race_video_rst_n", video_rst_n, 0);
      chk("race_pll_rst", pll_rst, 1);
      wait_state("race_rerun", 3, 40);

      // Lock loss in RUN, repeated until loss_cnt saturates
      for (int i = 1; i <= 256; i++) begin
         pll_locked = 1'b0;
         n = 0;
         while (video_rst_n && n < 10) begin
            tick();
            n++;
         end
         if (i == 1) begin
            chk("loss_latency", n, 3);
            chk("loss_state", state, 0);
            chk("loss_pll_rst", pll_rst, 1);
         end
         chk($sformatf("loss_cnt_%0d", i), loss_cnt, (i > 255) ? 255 : i);
         pll_locked = 1'b1;
         wait_state($sformatf("loss_relock_%0d", i), 3, 40);
      end

      // restart in RUN leaves loss_cnt alone
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("rst_run_state", state, 0);
      chk("rst_run_loss_cnt", loss_cnt, 255);
      chk("rst_run_retries", retries, 0);
      wait_state("rst_run_rerun", 3, 40);

      // Async reset between edges while in RUN
      @(posedge refclk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_state", state, 0);
      chk("arst_pll_rst", pll_rst, 1);
      chk("arst_video_rst_n", video_rst_n, 0);
      chk("arst_ready", ready, 0);
      chk("arst_fail", fail, 0);
      chk("arst_retries", retries, 0);
      chk("arst_loss_cnt", loss_cnt, 0);
      pll_locked = 1'b0;
      #1;
      rst_n = 1'b1;

      // No lock: two timeouts park in FAIL, then restart recovers
      wait_state("fail_reach", 4, 80);
      chk("fail_retries", retries, 2);
      chk("fail_flag", fail, 1);
      chk("fail_pll_rst", pll_rst, 1);
      held = 0;
      for (int k = 0; k < 120; k++) begin
         tick();
         if (state == 3'd4 && fail && pll_rst) held++;
      end
      chk("fail_held", held, 120);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("fail_restart_state", state, 0);
      chk("fail_restart_retries", retries, 0);
      chk("fail_restart_fail", fail, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
